// File: rtl/seq_pattern_ctrl.sv
// seq_pattern_ctrl: replays a {a,b,hold} pattern table into seq_circuit and logs its {y,z} per entry; SEQ_PATTERN_LOOP_EN enables looping
module seq_pattern_ctrl #(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [HOLD_W+1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] last_idx,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     loop,
  input  logic                     y_in,
  input  logic                     z_in,
  output logic                     a,
  output logic                     b,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step,
  output logic [2*DEPTH-1:0]       yz_log
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_state_nx;
  logic [HOLD_W+1:0] r_tab [DEPTH];
  logic [HOLD_W+1:0] w_cur, w_nxt, w_first;
  logic [AW-1:0] r_step, r_last, w_step_nx, w_last_nx, w_step_inc;
  logic [HOLD_W-1:0] r_cnt, w_cnt_nx;
  logic r_a, r_b, r_loop, w_a_nx, w_b_nx, w_loop_nx, w_loop_in;
  logic [2*DEPTH-1:0] r_yz, w_yz_nx;
`ifdef SEQ_PATTERN_LOOP_EN
  assign w_loop_in = loop;
`else
  assign w_loop_in = loop & 1'b0;
`endif
  assign w_cur      = r_tab[r_step];
  assign w_step_inc = r_step + 1'b1;
  assign w_nxt      = r_tab[w_step_inc];
  assign w_first    = r_tab[0];
  assign a      = r_a;
  assign b      = r_b;
  assign step   = r_step;
  assign yz_log = r_yz;
  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  // pattern table: writable only while idle, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_tab[i] <= '0;
    end else if (wr_en && r_state == IDLE) begin
      r_tab[wr_addr] <= wr_data;
    end
  end
  // state and run registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_loop  <= 1'b0;
      r_yz    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_step  <= w_step_nx;
      r_last  <= w_last_nx;
      r_cnt   <= w_cnt_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_loop  <= w_loop_nx;
      r_yz    <= w_yz_nx;
    end
  end
  // next state: hold counter per entry, capture {y,z} on an entry's last cycle, then advance/wrap/finish
  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_last_nx  = r_last;
    w_cnt_nx   = r_cnt;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_loop_nx  = r_loop;
    w_yz_nx    = r_yz;
    case (r_state)
      IDLE: if (start && !abort) begin
        w_state_nx = RUN;
        w_step_nx  = '0;
        w_cnt_nx   = '0;
        w_a_nx     = w_first[HOLD_W+1];
        w_b_nx     = w_first[HOLD_W];
        w_yz_nx    = '0;
        w_last_nx  = last_idx;
        w_loop_nx  = w_loop_in;
      end
      RUN: if (abort) begin
        w_state_nx = IDLE;
        w_step_nx  = '0;
        w_cnt_nx   = '0;
        w_a_nx     = 1'b0;
        w_b_nx     = 1'b0;
      end else if (r_cnt == w_cur[HOLD_W-1:0]) begin
        w_yz_nx[{r_step, 1'b0} +: 2] = {y_in, z_in};
        w_cnt_nx = '0;
        if (r_step != r_last) begin
          w_step_nx = w_step_inc;
          w_a_nx    = w_nxt[HOLD_W+1];
          w_b_nx    = w_nxt[HOLD_W];
        end else if (r_loop) begin
          w_step_nx = '0;
          w_a_nx    = w_first[HOLD_W+1];
          w_b_nx    = w_first[HOLD_W];
        end else begin
          w_state_nx = DONE;
          w_a_nx     = 1'b0;
          w_b_nx     = 1'b0;
        end
      end else begin
        w_cnt_nx = r_cnt + 1'b1;
      end
      DONE: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// tb_seq_pattern_ctrl: directed vectors, corner sequences and randomized runs against a queue-based model
module tb_seq_pattern_ctrl;
  localparam int DEPTH = 8, HOLD_W = 4, AW = 3;
  logic clk = 1'b0, rst, wr_en, start, abort, loop, y_in, z_in;
  logic [AW-1:0] wr_addr, last_idx, step;
  logic [HOLD_W+1:0] wr_data;
  logic a, b, busy, done;
  logic [2*DEPTH-1:0] yz_log, exp_yz;
  int n_chk = 0, n_err = 0, lst, ab_at, n;
  bit aborted, seen;
  logic [HOLD_W+1:0] m_tab [DEPTH];
  typedef struct { logic y, z, ea, eb, ebusy, edone; logic [AW-1:0] estep; } vec_t;
  typedef struct { logic a, b; logic [AW-1:0] s; bit fin; } cyc_t;
  vec_t vt [8];
  cyc_t cc;
  cyc_t q [$];
  always #5 clk = ~clk;
  seq_pattern_ctrl #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_idx(last_idx), .start(start), .abort(abort), .loop(loop),
    .y_in(y_in), .z_in(z_in), .a(a), .b(b), .busy(busy), .done(done),
    .step(step), .yz_log(yz_log)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int ad, input logic [HOLD_W+1:0] d);
    wr_en = 1'b1; wr_addr = ad[AW-1:0]; wr_data = d;
    tick;
    wr_en = 1'b0;
    m_tab[ad] = d;
  endtask
  task automatic pulse_start(input int l, input logic lp);
    last_idx = l[AW-1:0]; loop = lp; start = 1'b1;
    tick;
    start = 1'b0; loop = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
    rst = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; last_idx = 0;
    start = 0; abort = 0; loop = 0; y_in = 0; z_in = 0;
    #12;
    check("reset outputs", {a, b, busy, done, step, yz_log}, 0);
    @(negedge clk); rst = 1'b1;
    tick;
    @(negedge clk);
    check("idle after reset", {a, b, busy, done, step, yz_log}, 0);
    wr(0, 6'b01_0001); wr(1, 6'b11_0001); wr(2, 6'b01_0001); wr(3, 6'b00_0000);
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
    y_in = 1'b1; z_in = 1'b0;
    pulse_start(3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      y_in = vt[i].y; z_in = vt[i].z;
      @(negedge clk);
      check($sformatf("vec%0d", i), {a, b, busy, done, step},
            {vt[i].ea, vt[i].eb, vt[i].ebusy, vt[i].edone, vt[i].estep});
      if (i == 7) check("yz_log pattern", yz_log, 16'h00aa);
      tick;
    end
    @(negedge clk);
    check("done one cycle", {busy, done}, 0);
    abort = 1'b1; start = 1'b1;
    tick;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("start+abort idle", busy, 0);
    y_in = 1'b0; z_in = 1'b1;
    pulse_start(3, 1'b0);
    repeat (4) tick;
    @(negedge clk);
    check("abort at entry2", step, 2);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    @(negedge clk);
    check("abort outputs", {a, b, busy, done, step}, 0);
    check("abort yz retained", yz_log, 16'h0005);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("no done after abort", seen, 0);
    pulse_start(3, 1'b0);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (c == 2 || c == 3) begin wr_en = 1; wr_addr = 0; wr_data = 6'h3f; start = 1; end
      @(negedge clk);
      if (done) break;
      n++;
      tick;
      wr_en = 0; start = 0;
    end
    wr_en = 0; start = 0;
    check("run len, wr/start in RUN", n, 7);
    tick;
    pulse_start(0, 1'b0);
    @(negedge clk);
    check("single entry c1", {a, b, busy, done, step}, 7'b0110000);
    tick;
    @(negedge clk);
    check("single entry c2", {a, b, busy, done, step}, 7'b0110000);
    tick;
    @(negedge clk);
    check("single entry done", {a, b, busy, done}, 4'b0001);
    tick;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < DEPTH; i++) if ($urandom_range(0, 1) == 1) wr(i, 6'($urandom));
      lst = $urandom_range(0, DEPTH - 1);
      q.delete();
      for (int e = 0; e <= lst; e++)
        for (int k = 0; k <= int'(m_tab[e][HOLD_W-1:0]); k++) begin
          cc.a = m_tab[e][HOLD_W+1]; cc.b = m_tab[e][HOLD_W];
          cc.s = e[AW-1:0]; cc.fin = (k == int'(m_tab[e][HOLD_W-1:0]));
          q.push_back(cc);
        end
      ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, q.size() - 1) : -1;
      exp_yz = '0; aborted = 0;
      pulse_start(lst, 1'b0);
      for (int c = 0; c < q.size(); c++) begin
        y_in = 1'($urandom); z_in = 1'($urandom);
        abort = (c == ab_at);
        start = 1'($urandom); wr_en = 1'($urandom);
        wr_addr = 3'($urandom); wr_data = 6'($urandom);
        @(negedge clk);
        check("rand cycle", {a, b, busy, done, step}, {q[c].a, q[c].b, 1'b1, 1'b0, q[c].s});
        tick;
        abort = 0; start = 0; wr_en = 0;
        if (c == ab_at) begin aborted = 1; break; end
        if (q[c].fin) exp_yz[2*q[c].s +: 2] = {y_in, z_in};
      end
      @(negedge clk);
      if (aborted) check("rand abort", {a, b, busy, done, step}, 0);
      else check("rand done", {a, b, busy, done}, 4'b0001);
      check("rand yz_log", yz_log, exp_yz);
      if (!aborted) begin
        tick;
        @(negedge clk);
        check("rand idle", {busy, done}, 0);
      end
    end
    @(negedge clk);
    pulse_start(3, 1'b0);
    tick; tick;
    #2 rst = 1'b0;
    #1 check("async reset mid-run", {a, b, busy, done, step, yz_log}, 0);
    for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
    @(negedge clk); rst = 1'b1;
    tick;
`ifdef SEQ_PATTERN_LOOP_EN
    pulse_start(1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("loop cyc%0d", c), {a, b, busy, done, step}, {2'b00, 1'b1, 1'b0, 3'(c % 2)});
      tick;
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    @(negedge clk);
    check("loop abort", {a, b, busy, done, step}, 0);
`else
    pulse_start(1, 1'b1);
    @(negedge clk);
    check("zero table c1", {a, b, busy, done, step}, 7'b0010000);
    tick;
    @(negedge clk);
    check("zero table c2", {a, b, busy, done, step}, 7'b0010001);
    tick;
    @(negedge clk);
    check("loop ignored done", {a, b, busy, done}, 4'b0001);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
